// File: rtl/l1_mem_cache.sv
// l1_mem_cache
// Direct-mapped, write-through, no-write-allocate single-word-line cache
// between the B32P CPU bus and the memory unit (MU). Both sides use the
// start/busy handshake. Read hits complete in LOOKUP (2 posedges from the
// start edge). Misses, writes and uncached accesses go to the MU.
//
// Ports
//   clk, reset                  system clock, async active-high reset
//   cpu_address/data/we/start   CPU request (address/data/we latched on start)
//   cpu_q, cpu_busy             CPU read data and busy flag (registered)
//   mem_address/data/we/start   MU request fields and one-cycle start pulse
//   mem_q, mem_busy             MU read data and busy flag
//   stat_clear, stat_hits, stat_misses
//                               only present when CACHE_STATS_EN is defined
//
// Configuration macro: CACHE_STATS_EN adds hit/miss counters for cacheable reads.
module l1_mem_cache #(
    parameter int          INDEX_BITS  = 8,
    parameter logic [26:0] CACHE_LIMIT = 27'h0800000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] cpu_address,
    input  logic [31:0] cpu_data,
    input  logic        cpu_we,
    input  logic        cpu_start,
    output logic [31:0] cpu_q,
    output logic        cpu_busy,
    output logic [26:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_we,
    output logic        mem_start,
    input  logic [31:0] mem_q,
    input  logic        mem_busy
`ifdef CACHE_STATS_EN
    ,
    input  logic        stat_clear,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 27 - INDEX_BITS;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_MWAIT_HI = 3'd2,
        ST_MWAIT_LO = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t                state_r;
    state_t                next_state_s;

    logic [26:0]           addr_r;
    logic [31:0]           wdata_r;
    logic                  we_r;

    logic [LINES-1:0]      valid_r;
    logic [TAG_BITS-1:0]   tag_ram_r  [LINES];
    logic [31:0]           data_ram_r [LINES];

    logic [INDEX_BITS-1:0] index_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic                  cacheable_s;
    logic                  hit_s;

    logic                  latch_req_s;
    logic                  hit_done_s;
    logic                  issue_mem_s;
    logic                  mem_done_s;
    logic                  finish_s;
    logic                  fill_s;
    logic                  line_write_s;

    // Address split and tag compare on the latched request address
    always_comb begin
        index_s     = addr_r[INDEX_BITS-1:0];
        tag_s       = addr_r[26:INDEX_BITS];
        cacheable_s = (addr_r < CACHE_LIMIT);
        hit_s       = cacheable_s && valid_r[index_s] && (tag_ram_r[index_s] == tag_s);
    end

    // Next-state logic and one-cycle control strobes for the datapath
    always_comb begin
        next_state_s = state_r;
        latch_req_s  = 1'b0;
        hit_done_s   = 1'b0;
        issue_mem_s  = 1'b0;
        mem_done_s   = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_start) begin
                    latch_req_s  = 1'b1;
                    next_state_s = ST_LOOKUP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (hit_s && !we_r) begin
                    hit_done_s   = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    issue_mem_s  = 1'b1;
                    next_state_s = ST_MWAIT_HI;
                end
            end
            ST_MWAIT_HI: begin
                // mem_busy may already be high at the first sample
                if (mem_busy) begin
                    next_state_s = ST_MWAIT_LO;
                end else begin
                    next_state_s = ST_MWAIT_HI;
                end
            end
            ST_MWAIT_LO: begin
                if (!mem_busy) begin
                    mem_done_s   = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_MWAIT_LO;
                end
            end
            ST_DONE: begin
                finish_s     = 1'b1;
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Line updates: reads fill the line, writes only refresh a line already holding the word
    always_comb begin
        fill_s       = mem_done_s && cacheable_s && !we_r;
        line_write_s = mem_done_s && we_r && hit_s;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request latch, only open in IDLE so a start while busy is ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= 27'd0;
            wdata_r <= 32'd0;
            we_r    <= 1'b0;
        end else if (latch_req_s) begin
            addr_r  <= cpu_address;
            wdata_r <= cpu_data;
            we_r    <= cpu_we;
        end
    end

    // CPU-side outputs: busy flag and read data, held until the next completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_busy <= 1'b0;
            cpu_q    <= 32'd0;
        end else begin
            if (latch_req_s) begin
                cpu_busy <= 1'b1;
            end
            if (hit_done_s) begin
                cpu_q    <= data_ram_r[index_s];
                cpu_busy <= 1'b0;
            end
            if (mem_done_s && !we_r) begin
                cpu_q <= mem_q;
            end
            if (finish_s) begin
                cpu_busy <= 1'b0;
            end
        end
    end

    // MU-side outputs: fields loaded with the start pulse, which lasts one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_start   <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= 27'd0;
            mem_data    <= 32'd0;
        end else begin
            mem_start <= issue_mem_s;
            if (issue_mem_s) begin
                mem_address <= addr_r;
                mem_data    <= wdata_r;
                mem_we      <= we_r;
            end
            if (finish_s) begin
                mem_we <= 1'b0;
            end
        end
    end

    // Valid bits are the only cache state cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= '0;
        end else if (fill_s) begin
            valid_r[index_s] <= 1'b1;
        end
    end

    // Tag and data arrays, not reset (contents are qualified by valid_r)
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_ram_r[index_s]  <= tag_s;
            data_ram_r[index_s] <= mem_q;
        end else if (line_write_s) begin
            data_ram_r[index_s] <= wdata_r;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hits_r;
    logic [31:0] misses_r;
    logic        miss_event_s;

    // A cacheable read that leaves LOOKUP for the MU is a miss
    always_comb begin
        miss_event_s = issue_mem_s && cacheable_s && !we_r;
    end

    // Hit/miss counters; clear has priority over a coincident count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits_r   <= 32'd0;
            misses_r <= 32'd0;
        end else if (stat_clear) begin
            hits_r   <= 32'd0;
            misses_r <= 32'd0;
        end else begin
            if (hit_done_s) begin
                hits_r <= hits_r + 32'd1;
            end
            if (miss_event_s) begin
                misses_r <= misses_r + 32'd1;
            end
        end
    end

    assign stat_hits   = hits_r;
    assign stat_misses = misses_r;
`else
    // No statistics hardware in this build.
`endif

endmodule
